// File: rtl/mem_dump_reader_if.sv
// Bus bundle for the dump reader: read-only RAM port plus the byte stream to the UART.
interface mem_dump_reader_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic [31:0]           mem_dout;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output mem_addr, mem_en, tx_data, tx_valid,
    input  mem_dout, tx_ready
  );

  modport slave (
    input  mem_addr, mem_en, tx_data, tx_valid,
    output mem_dout, tx_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Debug dump reader: walks a block of RAM words and streams them out MSB byte first.
module mem_dump_reader #(
  parameter int ADDR_WIDTH  = 13,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  mem_dump_reader_if.master     bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, SKIP, FIN} state_t;

  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH+1)'(1);
  localparam logic [1:0]          LAT_LAST = 2'(MEM_LATENCY - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [1:0]            lat_cnt;
  logic [31:0]           shreg;
  logic [1:0]            byte_idx;
  logic                  mem_en_r;
  logic                  tx_valid_r;

  // addr doubles as the registered RAM address; it is advanced on the same
  // edge that raises mem_en so the REQ cycle already presents the next word.
  assign bus.mem_addr = addr;
  assign bus.mem_en   = mem_en_r;
  assign bus.tx_data  = shreg[31:24];
  assign bus.tx_valid = tx_valid_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      lat_cnt    <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
      mem_en_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_en_r <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= word_count;
            busy      <= 1'b1;
            if (word_count == '0) begin
              state <= SKIP;
            end else begin
              mem_en_r <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          lat_cnt <= LAT_LAST;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            shreg      <= bus.mem_dout;
            byte_idx   <= 2'd0;
            tx_valid_r <= 1'b1;
            state      <= SEND;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            shreg    <= {shreg[23:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              tx_valid_r <= 1'b0;
              addr       <= addr + 1'b1;
              remaining  <= remaining - 1'b1;
              if (remaining == ONE_WORD) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                mem_en_r <= 1'b1;
                state    <= REQ;
              end
            end
          end
        end
        // Zero-length dump: one busy cycle, then the done pulse.
        SKIP: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
